// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: access-size encodings and FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: extracts and extends a load lane from a memory word and
// merges sub-word store data into the addressed lane of a word.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_shift;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign byte_shift = {addr_lo_i, 3'b000};
    assign lane_byte  = 8'(word_i >> byte_shift);
    assign lane_half  = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        load_o   = word_i;
        merged_o = word_i;
        unique case (size_i)
            SZ_BYTE: begin
                load_o   = {{24{signed_i & lane_byte[7]}}, lane_byte};
                merged_o = (word_i & ~(32'h0000_00FF << byte_shift))
                         | ({24'b0, wdata_i[7:0]} << byte_shift);
            end
            SZ_HALF: begin
                load_o   = {{16{signed_i & lane_half[15]}}, lane_half};
                merged_o = addr_lo_i[1] ? {wdata_i, word_i[15:0]} : {word_i[31:16], wdata_i};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit for a single-ported word memory with combinational read. Handles
// sub-word loads with extension, sub-word stores by read-modify-write, and access faults.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    // Widened so that 4*MEM_WORDS cannot wrap for any legal parameter value.
    localparam logic [33:0] LIMIT = 34'(MEM_WORDS) * 34'(WORD_BYTES);

    state_e      state_q;
    logic        we_q;
    size_e       size_q;
    logic        signed_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_q;
    logic [29:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic        rsp_valid_q;
    logic        rsp_exc_q;
    logic [31:0] rsp_rdata_q;

    size_e       req_sz;
    logic [31:0] req_off;
    logic        req_fault;
    logic [31:0] load_data;
    logic [31:0] merged_data;

    assign req_sz  = size_e'(req_size);
    assign req_off = req_addr - BASE_ADDR;

    always_comb begin
        req_fault = 1'b0;
        unique case (req_sz)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = req_addr[0];
            SZ_WORD: req_fault = |req_addr[1:0];
            default: req_fault = 1'b1;
        endcase
        if ({2'b00, req_off} >= LIMIT) begin
            req_fault = 1'b1;
        end
    end

    mem_lane_align u_lane_align (
        .size_i   (size_q),
        .signed_i (signed_q),
        .addr_lo_i(addr_lo_q),
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merged_o (merged_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            addr_lo_q   <= 2'b00;
            wdata_q     <= 16'h0000;
            mem_addr_q  <= 30'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_exc_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_sz;
                        signed_q  <= req_signed;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        if (req_fault) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_exc_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q    <= ACCESS;
                            mem_addr_q <= req_off[31:2];
                            // Word stores write directly during ACCESS.
                            if (req_we && req_sz == SZ_WORD) begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    if (!we_q || size_q == SZ_WORD) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_exc_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'h0 : load_data;
                    end else begin
                        state_q     <= WRITE;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged_data;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_exc_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_exc_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_exc   = rsp_exc_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    // Reset is synchronous, so the write strobe is gated to keep an interrupted store
    // from landing on the very edge that resets the unit.
    assign mem_we    = mem_we_q & ~reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int unsigned WORDS = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(
        .MEM_WORDS(WORDS),
        .BASE_ADDR(BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_exc   (rsp_exc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'h8899AABB;
        if (i == 1) return 32'h11223344;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Attached memory: combinational read, write on rising edge.
    logic [31:0] mem [0:WORDS-1];
    bit          mem_init_done = 1'b0;
    assign mem_rdata = mem[mem_addr[11:0]];
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(WORDS); i++) mem[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[11:0]] <= mem_wdata;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle-time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [0:WORDS-1];
    int          cyc = 0;
    int          ready_from = 0;
    int          accept_cyc = 0;
    int          exp_rsp_cyc = -1;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_exc = 1'b0;
    int          exp_we_cyc = -1;
    logic [29:0] exp_we_addr = 30'h0;
    logic [31:0] exp_we_data = 32'h0;
    bit          checking = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_exc = 1'b0;
    int          last_lat = 0;
    int          we_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (checking) begin
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, cyc == exp_rsp_cyc});
            if (rsp_valid && cyc == exp_rsp_cyc) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_exc", {31'b0, rsp_exc}, {31'b0, exp_exc});
                last_rdata = rsp_rdata;
                last_exc   = rsp_exc;
                last_lat   = cyc - accept_cyc + 1;
            end
            chk("req_ready", {31'b0, req_ready}, {31'b0, cyc >= ready_from});
            chk("mem_we", {31'b0, mem_we}, {31'b0, cyc == exp_we_cyc});
            if (mem_we) begin
                we_pulses++;
                if (cyc == exp_we_cyc) begin
                    chk("mem_addr", {2'b0, mem_addr}, {2'b0, exp_we_addr});
                    chk("mem_wdata", mem_wdata, exp_we_data);
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit commit);
        int          n = 0;
        logic [31:0] off;
        bit          fault;
        int          idx;
        int          b;
        int          lat;
        logic [31:0] w;
        logic [31:0] v;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", {31'b0, req_ready}, 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        accept_cyc = cyc;

        off   = addr - BASE;
        fault = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
             || (size == 2'd2 && addr % 4 != 0) || (64'(off) >= 64'(WORDS) * 4);
        idx = int'(off / 4);
        b   = int'(off % 4);
        if (fault) begin
            lat = 1;
            exp_rdata = 32'h0;
            exp_exc = 1'b1;
        end else begin
            w = ref_mem[idx];
            exp_exc = 1'b0;
            if (!we) begin
                lat = 2;
                if (size == 2'd0) begin
                    v = (w >> (8 * b)) & 32'hFF;
                    if (sgn && v >= 32'h80) v = v + 32'hFFFFFF00;
                end else if (size == 2'd1) begin
                    v = (w >> (16 * (b / 2))) & 32'hFFFF;
                    if (sgn && v >= 32'h8000) v = v + 32'hFFFF0000;
                end else begin
                    v = w;
                end
                exp_rdata = v;
            end else begin
                exp_rdata = 32'h0;
                if (size == 2'd2) begin
                    lat = 2;
                    v = wdata;
                end else if (size == 2'd0) begin
                    lat = 3;
                    v = (w & ~(32'hFF << (8 * b))) | ((wdata & 32'hFF) << (8 * b));
                end else begin
                    lat = 3;
                    v = (w & ~(32'hFFFF << (8 * b))) | ((wdata & 32'hFFFF) << (8 * b));
                end
                exp_we_cyc  = (lat == 2) ? accept_cyc : accept_cyc + 1;
                exp_we_addr = 30'(idx);
                exp_we_data = v;
                if (commit) ref_mem[idx] = v;
            end
        end
        exp_rsp_cyc = accept_cyc + lat - 1;
        ready_from  = exp_rsp_cyc + 1;
    endtask

    task automatic drain();
        int n = 0;
        while (cyc < ready_from && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cyc < ready_from) chk("drain_timeout", 32'(cyc), 32'(ready_from));
    endtask

    initial begin
        int p;
        int r;
        int mode;
        int bad;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_val(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_exc", {31'b0, rsp_exc}, 32'd0);
        chk("reset_mem_we", {31'b0, mem_we}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_addr", {2'b0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checking = 1'b1;

        // Sub-word loads of word 0 = 8899AABB
        do_req(1'b0, SZ_BYTE, 1'b1, 32'd2, 32'h0, 1'b1);
        drain();
        chk("lb_signed_data", last_rdata, 32'hFFFFFF99);
        chk("lb_signed_lat", 32'(last_lat), 32'd2);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'd2, 32'h0, 1'b1);
        drain();
        chk("lb_unsigned_data", last_rdata, 32'h00000099);

        // Byte store into word 1 = 11223344
        p = we_pulses;
        do_req(1'b1, SZ_BYTE, 1'b0, 32'd5, 32'hCAFE_0055, 1'b1);
        drain();
        chk("sb_we_pulses", 32'(we_pulses - p), 32'd1);
        chk("sb_mem_word1", mem[1], 32'h11225544);
        chk("sb_lat", 32'(last_lat), 32'd3);

        // Faults
        p = we_pulses;
        do_req(1'b1, SZ_HALF, 1'b0, 32'd3, 32'h0000_BEEF, 1'b1);
        drain();
        chk("sh_misaligned_exc", {31'b0, last_exc}, 32'd1);
        chk("sh_misaligned_lat", 32'(last_lat), 32'd1);
        chk("sh_misaligned_no_we", 32'(we_pulses - p), 32'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'd16384, 32'h0, 1'b1);
        drain();
        chk("lw_out_of_range_exc", {31'b0, last_exc}, 32'd1);
        chk("lw_out_of_range_data", last_rdata, 32'd0);

        // Back-to-back word store then load
        do_req(1'b1, SZ_WORD, 1'b0, 32'd8, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        chk("ready_low_in_access", {31'b0, req_ready}, 32'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0, 1'b1);
        drain();
        chk("sw_lw_data", last_rdata, 32'hDEADBEEF);

        // Reset during WRITE of a byte store to word 1
        do_req(1'b1, SZ_BYTE, 1'b0, 32'd4, 32'h0000_00A5, 1'b0);
        @(posedge clk);
        #1;
        checking = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_write_no_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rsp_cyc = -1;
        exp_we_cyc = -1;
        ready_from = 0;
        @(negedge clk);
        chk("rst_write_mem_word1", mem[1], 32'h11225544);
        chk("rst_write_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_write_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_write_mem_addr", {2'b0, mem_addr}, 32'd0);
        chk("rst_write_mem_wdata", mem_wdata, 32'd0);
        chk("rst_write_idle", {31'b0, req_ready}, 32'd1);
        checking = 1'b1;

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            mode = $urandom_range(0, 9);
            if (mode < 5) begin
                a = $urandom_range(0, 63);
                if (sz == 2'd1) a = a & ~32'd1;
                if (sz == 2'd2) a = a & ~32'd3;
            end else if (mode < 7) begin
                a = $urandom_range(0, 63);
            end else if (mode < 9) begin
                a = $urandom_range(16376, 16391);
            end else begin
                a = $urandom;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                drain();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain();
        @(negedge clk);

        bad = 0;
        for (int i = 0; i < int'(WORDS); i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("final_memory_mismatches", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, giving the number of 32-bit words in the attached memory.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of memory word 0.
REQ-003 SHALL have port clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit, CPU request present.
REQ-006 SHALL have port req_ready, output, 1 bit, unit able to accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-009 SHALL have port req_signed, input, 1 bit: sign-extend sub-word loads when 1, zero-extend when 0.
REQ-010 SHALL have port req_addr, input, 32 bits, byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits, store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit, one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, 32 bits, extended load result; 0 for stores and exceptions.
REQ-014 SHALL have port rsp_exc, output, 1 bit, access fault, qualified by rsp_valid.
REQ-015 SHALL have port mem_addr, output, 30 bits (byte address bits 31:2), word address to memory.
REQ-016 SHALL have port mem_wdata, output, 32 bits, word write data.
REQ-017 SHALL have port mem_we, output, 1 bit, word write enable, sampled by memory at the rising clock edge.
REQ-018 SHALL have port mem_rdata, input, 32 bits, combinational word read of mem_addr.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request on the clk edge where req_valid && req_ready, registering we/size/signed/addr/wdata; inputs are ignored at all other times.
REQ-021 SHALL fault when size = 3, on halfword with addr[0] = 1, on word with addr[1:0] != 0, or when addr - BASE_ADDR >= 4*MEM_WORDS (unsigned).
REQ-022 SHALL, on an accepted faulting request, go IDLE -> RESP directly with rsp_exc = 1 and never assert mem_we.
REQ-023 SHALL, in ACCESS, drive mem_addr = (addr - BASE_ADDR)[31:2] and hold it through WRITE.
REQ-024 SHALL, for loads in ACCESS, capture the selected lane of mem_rdata; go to RESP. Byte lane is addr[1:0] (lane 0 = bits 7:0); half lane is addr[1] (0 = bits 15:0).
REQ-025 SHALL, for word stores in ACCESS, assert mem_we with mem_wdata = wdata; go to RESP.
REQ-026 SHALL, for sub-word stores in ACCESS, capture mem_rdata, merge the low byte/half of wdata into the addressed lane, then in WRITE assert mem_we with the merged word for exactly one cycle; go to RESP.
REQ-027 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; there is no back-pressure on the response.
REQ-028 SHALL have latency from the accept edge to rsp_valid of 1 cycle for faults, 2 for loads and word stores, and 3 for sub-word stores; the next request is accepted the cycle after RESP.
REQ-029 SHALL assert mem_we only in ACCESS (word store) or WRITE (sub-word store), never otherwise.

Reset
REQ-030 SHALL, when reset is high at a clk edge, force state IDLE and set rsp_valid, rsp_exc, mem_we, rsp_rdata, mem_addr and mem_wdata to 0, including mid-operation; an interrupted store SHALL NOT write.

Structure
REQ-031 SHALL take size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum from the shared package mem_pkg.
REQ-032 SHALL place lane extract/extend and lane merge in one combinational sub-module, mem_lane_align; the FSM stays in mem_access_unit.

Verification
REQ-033 SHALL check: memory word 0 = 32'h8899AABB; load byte signed at addr 2 -> rsp_rdata = 32'hFFFFFF99 two cycles after accept; unsigned -> 32'h00000099.
REQ-034 SHALL check: word 1 = 32'h11223344; store byte 8'h55 at addr 5 -> exactly one mem_we pulse; word 1 becomes 32'h11225544 and rsp_valid rises 3 cycles after accept.
REQ-035 SHALL check: store half 16'hBEEF at addr 3 -> rsp_exc = 1 one cycle after accept, no mem_we; load word at addr 16384 (MEM_WORDS=4096) -> rsp_exc = 1.
REQ-036 SHALL check: back-to-back word store of 32'hDEADBEEF at addr 8, then load word at addr 8 -> rsp_rdata = 32'hDEADBEEF; req_ready is low during ACCESS/RESP.
REQ-037 SHALL check: assert reset during the WRITE state of a sub-word store -> no mem_we that cycle, memory unchanged, outputs 0, state IDLE.
